// File: rtl/tcdm_bank_ctrl.sv
// Per-target TCDM bank controller: admits requests against response credit, drives a
// fixed-latency SRAM and returns tagged read (and optionally write) responses in order.
module tcdm_bank_ctrl #(
  parameter int unsigned NumIn        = 32,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned RespDepth    = 3,
  parameter bit          WriteResp    = 1'b0,
  localparam int unsigned IniAddrWidth = $clog2(NumIn)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [IniAddrWidth-1:0] req_ini_addr_i,
  input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
  input  logic                    req_wen_i,
  input  logic [DataWidth-1:0]    req_wdata_i,
  input  logic [BeWidth-1:0]      req_be_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [IniAddrWidth-1:0] resp_ini_addr_o,
  output logic [DataWidth-1:0]    resp_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrMemWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeWidth-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned CreditWidth = $clog2(RespDepth + 1);
  localparam int unsigned PtrWidth    = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(RespDepth);
  localparam logic [PtrWidth-1:0]    PtrLast   = PtrWidth'(RespDepth - 1);

  typedef struct packed {
    logic                    valid;
    logic [IniAddrWidth-1:0] ini;
    logic                    is_write;
  } stage_t;

  typedef struct packed {
    logic [IniAddrWidth-1:0] ini;
    logic [DataWidth-1:0]    data;
  } resp_t;

  logic [CreditWidth-1:0] credit_q, credit_d;
  logic [CreditWidth-1:0] count_q, count_d;
  logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
  stage_t                 pipe_q [MemLatency];
  stage_t                 pipe_d [MemLatency];
  resp_t                  fifo_q [RespDepth];
  resp_t                  fifo_d [RespDepth];

  logic  accept;
  logic  resp_gen;
  logic  take_credit;
  logic  push;
  logic  pop;
  stage_t out_stage;
  resp_t  push_entry;

  // Handshakes and SRAM drive; ready depends on registered credit only (and reset).
  always_comb begin
    req_ready_o     = !rst_i && (credit_q != '0);
    accept          = req_valid_i && req_ready_o;
    resp_gen        = !req_wen_i || WriteResp;
    take_credit     = accept && resp_gen;
    resp_valid_o    = !rst_i && (count_q != '0);
    pop             = resp_valid_o && resp_ready_i;
    out_stage       = pipe_q[MemLatency-1];
    push            = out_stage.valid;
    push_entry.ini  = out_stage.ini;
    push_entry.data = out_stage.is_write ? '0 : mem_rdata_i;
    resp_ini_addr_o = fifo_q[rd_ptr_q].ini;
    resp_rdata_o    = fifo_q[rd_ptr_q].data;
    mem_req_o       = accept;
    mem_we_o        = req_wen_i;
    mem_addr_o      = req_tgt_addr_i;
    mem_wdata_o     = req_wdata_i;
    mem_be_o        = req_be_i;
  end

  // Next state: credit, latency pipeline, response FIFO.
  always_comb begin
    credit_d = credit_q;
    if (take_credit && !pop) begin
      credit_d = credit_q - CreditWidth'(1);
    end else if (pop && !take_credit) begin
      credit_d = credit_q + CreditWidth'(1);
    end

    pipe_d[0].valid    = take_credit;
    pipe_d[0].ini      = req_ini_addr_i;
    pipe_d[0].is_write = req_wen_i;
    for (int unsigned i = 1; i < MemLatency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CreditWidth'(1);
      2'b01:   count_d = count_q - CreditWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q <= CreditMax;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < MemLatency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      credit_q <= credit_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      pipe_q   <= pipe_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (count_q == CreditMax)));
  a_credit_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(take_credit && !pop && (credit_q == '0)));
  a_credit_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop && !take_credit && (credit_q == CreditMax)));

endmodule

// File: tb/tb_tcdm_bank_ctrl.sv
// Scoreboard bench for tcdm_bank_ctrl: SRAM model, credit model and in-order response queue.
module tb_tcdm_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [4:0]  req_ini_addr_i = '0;
  logic [11:0] req_tgt_addr_i = '0;
  logic        req_wen_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_be_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [4:0]  resp_ini_addr_o;
  logic [31:0] resp_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = '0;

  logic        w_req_ready, w_resp_valid, w_mem_req, w_mem_we;
  logic [4:0]  w_resp_ini;
  logic [31:0] w_resp_rdata, w_mem_wdata;
  logic [11:0] w_mem_addr;
  logic [3:0]  w_mem_be;

  always #5 clk = ~clk;

  tcdm_bank_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ini_addr_i(req_ini_addr_i), .req_tgt_addr_i(req_tgt_addr_i),
    .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_ini_addr_o(resp_ini_addr_o), .resp_rdata_o(resp_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  tcdm_bank_ctrl #(.WriteResp(1'b1)) dut_wr (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(w_req_ready),
    .req_ini_addr_i(req_ini_addr_i), .req_tgt_addr_i(req_tgt_addr_i),
    .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .resp_valid_o(w_resp_valid), .resp_ready_i(resp_ready_i),
    .resp_ini_addr_o(w_resp_ini), .resp_rdata_o(w_resp_rdata),
    .mem_req_o(w_mem_req), .mem_we_o(w_mem_we), .mem_addr_o(w_mem_addr),
    .mem_wdata_o(w_mem_wdata), .mem_be_o(w_mem_be), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct packed {
    logic [4:0]  ini;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          credit_m = 3;
  logic [31:0] sram_next = '0;
  bit          chk_lat = 1'b0;
  bit          hold_prev = 1'b0;

  // Fixed SRAM contents; address 0x012 holds 0xDEADBEEF.
  function automatic logic [31:0] mem_f(input logic [11:0] a);
    return 32'hDEADBEEF + (32'(a) - 32'h12) * 32'h9E3779B9;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, update models.
  task automatic drive_cycle(input logic v, input logic wen, input logic [4:0] ini,
                             input logic [11:0] addr, input logic rr, input logic rst);
    logic exp_ready, acc, pop;
    exp_t e;
    @(negedge clk);
    rst_i          = rst;
    req_valid_i    = v;
    req_wen_i      = wen;
    req_ini_addr_i = ini;
    req_tgt_addr_i = addr;
    req_wdata_i    = $urandom();
    req_be_i       = 4'($urandom());
    resp_ready_i   = rr;
    mem_rdata_i    = sram_next;
    #1;
    exp_ready = !rst && (credit_m != 0);
    check_eq("req_ready", 64'(req_ready_o), 64'(exp_ready));
    check_eq("mem_req", 64'(mem_req_o), 64'(v && exp_ready));
    acc = v && req_ready_o;
    pop = resp_valid_o && rr;
    if (rst) check_eq("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    if (hold_prev && !rst) check_eq("resp_hold", 64'(resp_valid_o), 64'(1));
    if (exp_q.size() == 0) begin
      check_eq("resp_spurious", 64'(resp_valid_o), 64'(0));
    end else if (pop) begin
      e = exp_q.pop_front();
      check_eq("resp_ini", 64'(resp_ini_addr_o), 64'(e.ini));
      check_eq("resp_data", 64'(resp_rdata_o), 64'(e.data));
      if (chk_lat) check_eq("resp_latency", 64'(cyc - e.cyc), 64'(2));
    end
    if (acc) begin
      acc_cnt++;
      check_eq("mem_we", 64'(mem_we_o), 64'(wen));
      check_eq("mem_addr", 64'(mem_addr_o), 64'(addr));
      check_eq("mem_wdata", 64'(mem_wdata_o), 64'(req_wdata_i));
      check_eq("mem_be", 64'(mem_be_o), 64'(req_be_i));
      if (!wen) begin
        e.ini  = ini;
        e.data = mem_f(addr);
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
    end
    sram_next = (mem_req_o && !mem_we_o) ? mem_f(mem_addr_o) : $urandom();
    hold_prev = resp_valid_o && !rr && !rst;
    if (rst) begin
      credit_m = 3;
      exp_q.delete();
    end else begin
      credit_m = credit_m - ((acc && !wen) ? 1 : 0) + (pop ? 1 : 0);
    end
    cyc++;
  endtask

  initial begin
    int a0;
    int seen;

    // Reset for two cycles, then first idle cycle
    drive_cycle(0, 0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("post_rst_ready", 64'(req_ready_o), 64'(1));
    check_eq("post_rst_valid", 64'(resp_valid_o), 64'(0));
    check_eq("post_rst_mem_req", 64'(mem_req_o), 64'(0));

    // Single read ini 5, addr 0x012
    chk_lat = 1'b1;
    drive_cycle(1, 0, 5'd5, 12'h012, 1, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("single_drain", 64'(exp_q.size()), 64'(0));
    chk_lat = 1'b0;

    // Backpressure: five reads, only three fit
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++) drive_cycle(1, 0, 5'(i + 8), 12'(12'h100 + i), 0, 0);
    for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 0, 0, 0);
    check_eq("bp_accepts", 64'(acc_cnt - a0), 64'(3));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 0, 0, 0, 1, 0);
      if (seen == 1) begin
        check_eq("bp_ready_back", 64'(req_ready_o), 64'(1));
        seen = 2;
      end
      if (seen == 0 && resp_valid_o) seen = 1;
    end
    check_eq("bp_drain", 64'(exp_q.size()), 64'(0));

    // Throughput: 20 back-to-back reads
    chk_lat = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 20; i++) drive_cycle(1, 0, 5'(i), 12'($urandom()), 1, 0);
    check_eq("tp_accepts", 64'(acc_cnt - a0), 64'(20));
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("tp_drain", 64'(exp_q.size()), 64'(0));
    chk_lat = 1'b0;

    // Writes without responses
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 5'(i), 12'(12'h200 + i), 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("wr_accepts", 64'(acc_cnt - a0), 64'(4));
    check_eq("wr_credit_full", 64'(req_ready_o), 64'(1));

    // Write response variant
    drive_cycle(0, 0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 1, 1);
    drive_cycle(1, 1, 5'd2, 12'h055, 1, 0);
    check_eq("wr1_ready", 64'(w_req_ready), 64'(1));
    check_eq("wr1_mem_req", 64'(w_mem_req), 64'(1));
    check_eq("wr1_mem_we", 64'(w_mem_we), 64'(1));
    check_eq("wr1_mem_addr", 64'(w_mem_addr), 64'(12'h055));
    check_eq("wr1_mem_wdata", 64'(w_mem_wdata), 64'(req_wdata_i));
    check_eq("wr1_mem_be", 64'(w_mem_be), 64'(req_be_i));
    drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("wr1_t1_valid", 64'(w_resp_valid), 64'(0));
    drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("wr1_t2_valid", 64'(w_resp_valid), 64'(1));
    check_eq("wr1_t2_ini", 64'(w_resp_ini), 64'(2));
    check_eq("wr1_t2_data", 64'(w_resp_rdata), 64'(0));
    drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("wr1_t3_valid", 64'(w_resp_valid), 64'(0));

    // Mid-operation reset drops in-flight reads
    drive_cycle(1, 0, 5'd7, 12'h300, 1, 0);
    drive_cycle(1, 0, 5'd9, 12'h301, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, 0, 1, 0);
    check_eq("midrst_ready", 64'(req_ready_o), 64'(1));
    check_eq("midrst_valid", 64'(resp_valid_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_ctrl.md
Name: tcdm_bank_ctrl

Overview:
- Per-target bank controller that sits on each target port of the variable-latency interconnect.
- Converts the valid/ready request stream into fixed-latency SRAM accesses, buffers read responses tagged with the initiator address, and returns them over a valid/ready response channel.
- Uses credit-based admission so it never accepts a request it cannot later buffer a response for.
- This guarantees the interconnect's response path can stall arbitrarily without loss.

Parameters:
- NumIn, 32, number of initiators; IniAddrWidth = $clog2(NumIn).
- AddrMemWidth, 12, SRAM word-address width.
- DataWidth, 32, data word width.
- BeWidth, DataWidth/8, byte-enable width.
- MemLatency, 1, SRAM read latency in cycles; legal range 1..4.
- RespDepth, 3, response FIFO depth; must be >= 1. Full throughput requires RespDepth >= MemLatency+2.
- WriteResp, 1'b0, when 1 writes return a response with rdata = '0; when 0 writes produce no response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_ini_addr_i  in  IniAddrWidth  initiator address
- req_tgt_addr_i  in  AddrMemWidth  word address
- req_wen_i  in  1  write enable
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  BeWidth  byte enable
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_ini_addr_o  out  IniAddrWidth  initiator address of response
- resp_rdata_o  out  DataWidth  response data
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AddrMemWidth  SRAM address
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enable
- mem_rdata_i  in  DataWidth  SRAM read data, valid MemLatency cycles after the sampling edge

Behaviour:
- Reset (rst_i high at a clock edge):
  - credit := RespDepth; latency pipeline valid bits := 0; FIFO empty.
  - While rst_i is high: req_ready_o = 0, mem_req_o = 0, resp_valid_o = 0.
  - Reset mid-operation drops all in-flight and buffered responses; no response is emitted for them.
- Credit counter:
  - Width $clog2(RespDepth+1); range 0..RespDepth.
  - req_ready_o = (credit != 0); registered state only, no combinational path from resp_ready_i or req_valid_i.
  - A response-generating request is a read, or a write when WriteResp = 1.
  - Accept = req_valid_i & req_ready_o.
  - Accept of a response-generating request decrements credit; FIFO pop (resp_valid_o & resp_ready_i) increments credit.
  - Both in the same cycle: credit unchanged.
  - Writes with WriteResp = 0 still require credit != 0 to be accepted but do not consume credit.
- SRAM drive (combinational in the accept cycle t):
  - mem_req_o = accept; mem_we_o = req_wen_i.
  - mem_addr_o, mem_wdata_o, mem_be_o = corresponding request fields.
  - When mem_req_o = 0, the mem_* fields are don't-care.
- Latency pipeline:
  - MemLatency stages carrying {valid, ini_addr, is_write}.
  - Stage 0 loads on accept of a response-generating request.
  - At the output stage (cycle t+MemLatency), push {ini_addr, is_write ? '0 : mem_rdata_i} into the FIFO.
  - The push never overflows: guaranteed by credit; assert on overflow.
- Response FIFO:
  - In-order, not fall-through.
  - Entry pushed in cycle t+MemLatency is visible on resp_* in cycle t+MemLatency+1.
  - resp_* stable while resp_valid_o = 1 and resp_ready_i = 0.
  - Push and pop in the same cycle are allowed, at any occupancy.
- Ordering: responses leave in acceptance order.
- Min read latency: accept in cycle t, response in cycle t+MemLatency+1.
- Full throughput: one accept per cycle sustained iff RespDepth >= MemLatency+2 and resp_ready_i stays high.
- Width rules: credit arithmetic saturates by construction (never below 0 or above RespDepth); assertions on violation.

Test Plan (MemLatency = 1, RespDepth = 3, WriteResp = 0 unless stated):
- Reset: hold rst_i for 2 cycles, then release -> cycle after release req_ready_o = 1, resp_valid_o = 0, mem_req_o = 0, credit = 3.
- Single read, ini 5, addr 0x012, accepted in cycle t -> mem_req_o = 1, mem_we_o = 0, mem_addr_o = 0x012 in t; mem_rdata_i = 0xDEADBEEF in t+1 -> resp_valid_o = 1, rdata 0xDEADBEEF, ini 5 in t+2.
- Backpressure: resp_ready_i = 0, 5 back-to-back reads -> exactly 3 accepted, req_ready_o = 0 from the 4th cycle. Raise resp_ready_i -> 3 responses in order; req_ready_o returns to 1 the cycle after the first pop.
- Throughput: resp_ready_i = 1, 20 consecutive reads -> 20 accepts in 20 cycles, 20 in-order responses with 2-cycle latency each.
- Writes: WriteResp = 0, 4 writes -> no resp_valid_o, credit stays 3. WriteResp = 1, write ini 2 -> response with ini 2, rdata 0x0 two cycles later.
- Mid-operation reset: 2 reads accepted, rst_i asserted in the cycle their rdata arrives -> no resp_valid_o afterwards, credit = 3 after reset.
